id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 32, instruction width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, PC width in bits.
REQ-003 SHALL have parameter IMM_TYPE_NUM, default 4, immediate-type count; imm_type width = $clog2(IMM_TYPE_NUM).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port flush  input  1  synchronous pipeline kill.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_inst (input, INST_WIDTH), in_pc (input, ADDR_WIDTH): fetch-side handshake.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_inst (output, INST_WIDTH), out_pc (output, ADDR_WIDTH): immediate-generator/execute-side handshake.
REQ-009 SHALL have ports out_imm_type (output, $clog2(IMM_TYPE_NUM)), out_uses_imm (output, 1), out_rs1/out_rs2/out_rd (output, 5 each), out_illegal (output, 1).

Function
REQ-010 SHALL transfer on input when in_valid && in_ready, on output when out_valid && out_ready.
REQ-011 SHALL hold one output register stage plus one skid entry; in_ready SHALL equal !skid_valid, driven from a register (no combinational path from out_ready).
REQ-012 SHALL present an accepted instruction on out_* the cycle after acceptance when the output stage is empty or draining (latency 1, throughput 1/cycle).
REQ-013 SHALL place an accepted instruction in the skid entry when output holds valid data and out_ready=0; in_ready falls next cycle.
REQ-014 SHALL move skid to output on the output transfer cycle, preserving order; a simultaneous input accept then lands in output-after-skid order (skid refilled if output still occupied).
REQ-015 SHALL keep all out_* stable while out_valid && !out_ready.
REQ-016 SHALL decode imm_type from in_inst[6:0] before registering: STORE 0100011 -> 2'b00; OP-IMM 0010011 or OP-IMM-32 0011011 with funct3 001/101 -> 2'b01; other OP-IMM/OP-IMM-32, LOAD 0000011, JALR 1100111 -> 2'b10; LUI 0110111, AUIPC 0010111 -> 2'b11.
REQ-017 SHALL set out_uses_imm=1 for opcodes in REQ-016, else 0 with out_imm_type=2'b10.
REQ-018 SHALL set out_illegal=1 for opcodes not in REQ-016 and not OP 0110011, OP-32 0111011, BRANCH 1100011, JAL 1101111, SYSTEM 1110011, or when in_inst[1:0]!=2'b11.
REQ-019 SHALL extract out_rd=inst[11:7], out_rs1=inst[19:15], out_rs2=inst[24:20] unconditionally.
REQ-020 SHALL, on flush=1, clear out_valid and skid_valid next edge; any input accepted in the flush cycle is discarded; flush overrides all simultaneous transfers.

Reset
REQ-021 SHALL, while rst_n=0, force out_valid=0, skid_valid=0, in_ready=1, all out_* data fields 0.
REQ-022 SHALL resume accepting on the first rising edge after rst_n deasserts; reset mid-transfer drops all held instructions.

Structure
REQ-023 SHALL take opcode constants and imm_type encodings (S=00, SHIFT=01, I=10, U=11) from the shared CPU package, also used by the immediate generator.
REQ-024 SHALL isolate the opcode->imm_type/uses_imm/illegal logic in one combinational sub-module, id_imm_sel.

Verification
REQ-025 SHALL cover: reset release, in_valid=1 in_inst=0x00A00093 (ADDI) out_ready=1 -> next cycle out_valid=1, out_imm_type=10, out_rd=1, out_uses_imm=1.
REQ-026 SHALL cover: out_ready=0, send 0x00113423 (SD) then 0x00209013 (SLLI) -> in_ready=0 after second; out holds SD (imm_type 00); raise out_ready -> SLLI (imm_type 01) next cycle, in_ready=1.
REQ-027 SHALL cover: 0x123452B7 (LUI) -> out_imm_type=11, out_rd=5; 0x002081B3 (ADD) -> out_uses_imm=0, out_illegal=0.
REQ-028 SHALL cover: in_inst=0x0000007F -> out_illegal=1; in_inst=0x00000000 -> out_illegal=1.
REQ-029 SHALL cover: output and skid both full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed instruction never appears.
REQ-030 SHALL cover: rst_n pulsed low mid-stream for half a cycle -> out_valid=0 immediately, in_ready=1, no stale output after release.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared CPU decode constants: base opcodes and immediate-type encodings.
// The immediate generator downstream relies on the same encodings.
package id_stage_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [1:0] {
    IMM_S     = 2'b00,
    IMM_SHIFT = 2'b01,
    IMM_I     = 2'b10,
    IMM_U     = 2'b11
  } imm_type_e;

  // Shift-immediate forms (SLLI/SRLI/SRAI and their -W variants) use funct3 001/101.
  function automatic logic is_shift_funct3(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/id_imm_sel.sv
// Opcode classifier: immediate type, immediate use and illegal-opcode flag.
// Purely combinational; evaluated on the incoming instruction before it is registered.
module id_imm_sel
  import id_stage_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output imm_type_e  imm_type,
  output logic       uses_imm,
  output logic       illegal
);

  // Classify the opcode; anything not recognised is illegal and reports IMM_I.
  // Every listed opcode ends in 2'b11, so a non-32-bit encoding falls to the default.
  always_comb begin
    imm_type = IMM_I;
    uses_imm = 1'b0;
    illegal  = 1'b1;
    unique case (opcode)
      OPC_STORE: begin
        imm_type = IMM_S;
        uses_imm = 1'b1;
        illegal  = 1'b0;
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        imm_type = is_shift_funct3(funct3) ? IMM_SHIFT : IMM_I;
        uses_imm = 1'b1;
        illegal  = 1'b0;
      end
      OPC_LOAD, OPC_JALR: begin
        imm_type = IMM_I;
        uses_imm = 1'b1;
        illegal  = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_type = IMM_U;
        uses_imm = 1'b1;
        illegal  = 1'b0;
      end
      OPC_OP, OPC_OP_32, OPC_BRANCH, OPC_JAL, OPC_SYSTEM: begin
        illegal = 1'b0;
      end
      default: begin
        imm_type = IMM_I;
        uses_imm = 1'b0;
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: one output register plus one skid entry.
// in_ready comes straight from the skid flag so there is no combinational
// path from out_ready back to the fetch side.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int INST_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 64,
  parameter int IMM_TYPE_NUM = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [INST_WIDTH-1:0]           in_inst,
  input  logic [ADDR_WIDTH-1:0]           in_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [INST_WIDTH-1:0]           out_inst,
  output logic [ADDR_WIDTH-1:0]           out_pc,
  output logic [$clog2(IMM_TYPE_NUM)-1:0] out_imm_type,
  output logic                            out_uses_imm,
  output logic [4:0]                      out_rs1,
  output logic [4:0]                      out_rs2,
  output logic [4:0]                      out_rd,
  output logic                            out_illegal
);

  localparam int ITW = $clog2(IMM_TYPE_NUM);

  imm_type_e             dec_imm_type;
  logic [ITW-1:0]        dec_imm_type_w;
  logic                  dec_uses_imm;
  logic                  dec_illegal;

  logic                  out_valid_q;
  logic [INST_WIDTH-1:0] out_inst_q;
  logic [ADDR_WIDTH-1:0] out_pc_q;
  logic [ITW-1:0]        out_imm_type_q;
  logic                  out_uses_imm_q;
  logic                  out_illegal_q;

  logic                  skid_valid_q;
  logic [INST_WIDTH-1:0] skid_inst_q;
  logic [ADDR_WIDTH-1:0] skid_pc_q;
  logic [ITW-1:0]        skid_imm_type_q;
  logic                  skid_uses_imm_q;
  logic                  skid_illegal_q;

  logic                  in_fire;
  logic                  out_free;

  id_imm_sel u_imm_sel (
    .opcode   (in_inst[6:0]),
    .funct3   (in_inst[14:12]),
    .imm_type (dec_imm_type),
    .uses_imm (dec_uses_imm),
    .illegal  (dec_illegal)
  );

  assign dec_imm_type_w = ITW'(dec_imm_type);

  assign in_ready = !skid_valid_q;
  assign in_fire  = in_valid && in_ready;
  // Output register can take new data this edge: empty, or being consumed now.
  assign out_free = !out_valid_q || out_ready;

  // Output register: skid entry has priority over a new input to keep order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_inst_q     <= '0;
      out_pc_q       <= '0;
      out_imm_type_q <= '0;
      out_uses_imm_q <= 1'b0;
      out_illegal_q  <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_q    <= 1'b1;
        out_inst_q     <= skid_inst_q;
        out_pc_q       <= skid_pc_q;
        out_imm_type_q <= skid_imm_type_q;
        out_uses_imm_q <= skid_uses_imm_q;
        out_illegal_q  <= skid_illegal_q;
      end else if (in_fire) begin
        out_valid_q    <= 1'b1;
        out_inst_q     <= in_inst;
        out_pc_q       <= in_pc;
        out_imm_type_q <= dec_imm_type_w;
        out_uses_imm_q <= dec_uses_imm;
        out_illegal_q  <= dec_illegal;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Skid entry: catches an accepted instruction while the output is stalled,
  // and is refilled from the input if it drains in the same cycle as an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q    <= 1'b0;
      skid_inst_q     <= '0;
      skid_pc_q       <= '0;
      skid_imm_type_q <= '0;
      skid_uses_imm_q <= 1'b0;
      skid_illegal_q  <= 1'b0;
    end else if (flush) begin
      skid_valid_q <= 1'b0;
    end else if ((skid_valid_q && out_free && in_fire) ||
                 (!skid_valid_q && !out_free && in_fire)) begin
      skid_valid_q    <= 1'b1;
      skid_inst_q     <= in_inst;
      skid_pc_q       <= in_pc;
      skid_imm_type_q <= dec_imm_type_w;
      skid_uses_imm_q <= dec_uses_imm;
      skid_illegal_q  <= dec_illegal;
    end else if (skid_valid_q && out_free) begin
      skid_valid_q <= 1'b0;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_inst     = out_inst_q;
  assign out_pc       = out_pc_q;
  assign out_imm_type = out_imm_type_q;
  assign out_uses_imm = out_uses_imm_q;
  assign out_illegal  = out_illegal_q;
  assign out_rd       = out_inst_q[11:7];
  assign out_rs1      = out_inst_q[19:15];
  assign out_rs2      = out_inst_q[24:20];

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [1:0]  out_imm_type;
  logic        out_uses_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  id_stage #(.INST_WIDTH(32), .ADDR_WIDTH(64), .IMM_TYPE_NUM(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_imm_type (out_imm_type),
    .out_uses_imm (out_uses_imm),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_illegal  (out_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference decode written from the opcode tables.
  function automatic void ref_dec(input logic [31:0] i, output int ty, output bit uses, output bit ill);
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    uses = 1'b1;
    ill  = 1'b0;
    ty   = 2;
    if (op == 7'h23) ty = 0;
    else if (op == 7'h13 || op == 7'h1B) ty = (f3 == 3'd1 || f3 == 3'd5) ? 1 : 2;
    else if (op == 7'h03 || op == 7'h67) ty = 2;
    else if (op == 7'h37 || op == 7'h17) ty = 3;
    else begin
      uses = 1'b0;
      ty   = 2;
      ill  = !(op inside {7'h33, 7'h3B, 7'h63, 7'h6F, 7'h73});
    end
    if (i[1:0] != 2'b11) ill = 1'b1;
  endfunction

  task automatic check_model(input string ctx);
    int ty;
    bit uses;
    bit ill;
    chk({ctx, ".in_ready"}, 64'(in_ready), 64'(q.size() < 2));
    chk({ctx, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      ref_dec(q[0].inst, ty, uses, ill);
      chk({ctx, ".out_inst"}, 64'(out_inst), 64'(q[0].inst));
      chk({ctx, ".out_pc"}, out_pc, q[0].pc);
      chk({ctx, ".imm_type"}, 64'(out_imm_type), 64'(ty));
      chk({ctx, ".uses_imm"}, 64'(out_uses_imm), 64'(uses));
      chk({ctx, ".illegal"}, 64'(out_illegal), 64'(ill));
      chk({ctx, ".rd"}, 64'(out_rd), 64'(q[0].inst[11:7]));
      chk({ctx, ".rs1"}, 64'(out_rs1), 64'(q[0].inst[19:15]));
      chk({ctx, ".rs2"}, 64'(out_rs2), 64'(q[0].inst[24:20]));
    end
  endtask

  // One clock: the model decides transfers from the pre-edge view, then both are compared.
  task automatic tick(input string ctx);
    bit acc;
    bit drn;
    acc = in_valid && (q.size() < 2);
    drn = (q.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{inst: in_inst, pc: in_pc});
    end
    check_model(ctx);
  endtask

  task automatic send(input logic [31:0] inst, input logic [63:0] pc, input string ctx);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    tick(ctx);
    in_valid = 1'b0;
  endtask

  // Called at posedge+1; pulses reset low for half a cycle between edges.
  task automatic reset_pulse(input string ctx);
    #1 rst_n = 1'b0;
    #1;
    chk({ctx, ".rst_out_valid"}, 64'(out_valid), 64'd0);
    chk({ctx, ".rst_in_ready"}, 64'(in_ready), 64'd1);
    chk({ctx, ".rst_out_inst"}, 64'(out_inst), 64'd0);
    chk({ctx, ".rst_out_pc"}, out_pc, 64'd0);
    q.delete();
    #5 rst_n = 1'b1;
  endtask

  logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33, 7'h37,
                            7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F, 7'h0B};

  initial begin
    logic [31:0] r;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    chk("reset.out_inst", 64'(out_inst), 64'd0);
    chk("reset.out_pc", out_pc, 64'd0);
    chk("reset.imm_type", 64'(out_imm_type), 64'd0);
    chk("reset.uses_imm", 64'(out_uses_imm), 64'd0);
    chk("reset.illegal", 64'(out_illegal), 64'd0);
    chk("reset.rd", 64'(out_rd), 64'd0);
    #3 rst_n = 1'b1;

    // ADDI with downstream ready: visible one cycle later.
    out_ready = 1'b1;
    send(32'h00A00093, 64'h1000, "addi");
    chk("addi.valid", 64'(out_valid), 64'd1);
    chk("addi.imm_type", 64'(out_imm_type), 64'd2);
    chk("addi.rd", 64'(out_rd), 64'd1);
    chk("addi.uses_imm", 64'(out_uses_imm), 64'd1);
    tick("addi_drain");

    // Stall: SD in output, SLLI in skid.
    out_ready = 1'b0;
    send(32'h00113423, 64'h1004, "sd");
    send(32'h00209013, 64'h1008, "slli");
    chk("stall.in_ready", 64'(in_ready), 64'd0);
    chk("stall.out_inst", 64'(out_inst), 64'h00113423);
    chk("stall.imm_type", 64'(out_imm_type), 64'd0);
    tick("stall_hold");
    chk("stall.hold_inst", 64'(out_inst), 64'h00113423);
    out_ready = 1'b1;
    tick("unstall");
    chk("unstall.out_inst", 64'(out_inst), 64'h00209013);
    chk("unstall.imm_type", 64'(out_imm_type), 64'd1);
    chk("unstall.in_ready", 64'(in_ready), 64'd1);
    tick("unstall_drain");

    // LUI then ADD back to back.
    send(32'h123452B7, 64'h2000, "lui");
    chk("lui.imm_type", 64'(out_imm_type), 64'd3);
    chk("lui.rd", 64'(out_rd), 64'd5);
    send(32'h002081B3, 64'h2004, "add");
    chk("add.uses_imm", 64'(out_uses_imm), 64'd0);
    chk("add.illegal", 64'(out_illegal), 64'd0);
    chk("add.imm_type", 64'(out_imm_type), 64'd2);

    // Illegal encodings.
    send(32'h0000007F, 64'h2008, "ill7f");
    chk("ill7f.illegal", 64'(out_illegal), 64'd1);
    send(32'h00000000, 64'h200C, "ill00");
    chk("ill00.illegal", 64'(out_illegal), 64'd1);
    tick("ill_drain");

    // Flush with both stages full and in_valid high.
    out_ready = 1'b0;
    send(32'h00A00093, 64'h3000, "fl_a");
    send(32'h00113423, 64'h3004, "fl_b");
    in_valid = 1'b1;
    in_inst  = 32'h123452B7;
    in_pc    = 64'h3008;
    flush    = 1'b1;
    tick("flush_full");
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick("flush_after");

    // Flush while an input is actually accepted: it must be discarded.
    send(32'h00A00093, 64'h3100, "fl2_a");
    in_valid = 1'b1;
    in_inst  = 32'h00209013;
    in_pc    = 64'h3104;
    flush    = 1'b1;
    tick("flush_accept");
    flush    = 1'b0;
    in_valid = 1'b0;
    tick("flush_accept_after");
    chk("flush_accept.gone", 64'(out_valid), 64'd0);

    // Mid-stream half-cycle reset with both stages occupied.
    out_ready = 1'b0;
    send(32'h00A00093, 64'h4000, "rs_a");
    send(32'h00113423, 64'h4004, "rs_b");
    reset_pulse("mid");
    out_ready = 1'b1;
    tick("post_reset");
    chk("post_reset.no_stale", 64'(out_valid), 64'd0);
    send(32'h002081B3, 64'h4008, "post_reset_add");

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      r         = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_inst   = (r[3:0] == 4'd0) ? $urandom : {r[31:7], ops[$urandom_range(0, 13)]};
      in_pc     = {$urandom, $urandom};
      if (n == 200) reset_pulse("rand_rst");
      tick("rand");
    end
    flush    = 1'b0;
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
